// File: rtl/bip_datapath.sv
// ---------------------------------------------------------------------------
// bip_datapath
// Execution datapath of the BIP I processor. It holds the accumulator (ACC),
// runs the ADD/SUB/pass-through ALU, drives the data-memory address and write
// data, and keeps a sticky halt flag plus a saturating cycle counter for the
// debug/UART reporting path.
//
// Ports
//   i_clock          system clock, all state updates on the rising edge
//   i_soft_reset     synchronous active-low reset
//   i_opcode         decoded opcode from the control unit
//   i_operand        operand field (signed immediate or data address)
//   i_selA           ACC source: 0 mem, 1 imm, 2 ALU, 3 hold
//   i_selB           ALU B operand: 0 mem, 1 imm
//   i_wrAcc          ACC write enable
//   i_data_mem       data-memory read data
//   o_addr_data_mem  data-memory address (combinational from operand)
//   o_data_mem       data-memory write data (current ACC)
//   o_acc            accumulator value
//   o_halt           sticky halt flag
//   o_cycle_count    cycles executed since reset, saturating
// ---------------------------------------------------------------------------
module bip_datapath #(
  parameter int unsigned OPCODE_LENGTH  = 5,
  parameter int unsigned OPERAND_LENGTH = 11,
  parameter int unsigned DATA_LENGTH    = 16,
  parameter int unsigned DATA_ADDR_BITS = 11,
  parameter int unsigned CNT_BITS       = 32
) (
  input  logic                      i_clock,
  input  logic                      i_soft_reset,
  input  logic [OPCODE_LENGTH-1:0]  i_opcode,
  input  logic [OPERAND_LENGTH-1:0] i_operand,
  input  logic [1:0]                i_selA,
  input  logic                      i_selB,
  input  logic                      i_wrAcc,
  input  logic [DATA_LENGTH-1:0]    i_data_mem,
  output logic [DATA_ADDR_BITS-1:0] o_addr_data_mem,
  output logic [DATA_LENGTH-1:0]    o_data_mem,
  output logic [DATA_LENGTH-1:0]    o_acc,
  output logic                      o_halt,
  output logic [CNT_BITS-1:0]       o_cycle_count
);

  localparam int unsigned EXT_BITS = DATA_LENGTH - OPERAND_LENGTH;

  localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = OPCODE_LENGTH'(5'b00000);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(5'b00100);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(5'b00101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(5'b00110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = OPCODE_LENGTH'(5'b00111);

  logic [DATA_LENGTH-1:0] acc_q, acc_d;
  logic                   halt_q, halt_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;

  logic [DATA_LENGTH-1:0] ext_c;
  logic [DATA_LENGTH-1:0] b_op_c;
  logic [DATA_LENGTH-1:0] alu_c;
  logic [DATA_LENGTH-1:0] acc_src_c;

  // Sign-extend the operand field to the data width.
  assign ext_c = {{EXT_BITS{i_operand[OPERAND_LENGTH-1]}}, i_operand};

  // ALU B operand select.
  assign b_op_c = i_selB ? ext_c : i_data_mem;

  // ALU: add / subtract modulo 2^DATA_LENGTH, otherwise pass B through.
  always_comb begin
    alu_c = b_op_c;
    case (i_opcode)
      OP_ADD, OP_ADDI: alu_c = acc_q + b_op_c;
      OP_SUB, OP_SUBI: alu_c = acc_q - b_op_c;
      default:         alu_c = b_op_c;
    endcase
  end

  // ACC source mux.
  always_comb begin
    acc_src_c = acc_q;
    case (i_selA)
      2'd0:    acc_src_c = i_data_mem;
      2'd1:    acc_src_c = ext_c;
      2'd2:    acc_src_c = alu_c;
      default: acc_src_c = acc_q;
    endcase
  end

  // Next state: everything freezes once halted; the HLT edge itself still
  // loads ACC and counts, the freeze starts on the following edge.
  always_comb begin
    acc_d  = acc_q;
    halt_d = halt_q;
    cnt_d  = cnt_q;
    if (!halt_q) begin
      if (i_wrAcc) acc_d = acc_src_c;
      if (i_opcode == OP_HLT) halt_d = 1'b1;
      if (cnt_q != {CNT_BITS{1'b1}}) cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      acc_q  <= '0;
      halt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      halt_q <= halt_d;
      cnt_q  <= cnt_d;
    end
  end

  // STO presents the pre-edge ACC; the write strobe lives in the control unit.
  assign o_addr_data_mem = i_operand[DATA_ADDR_BITS-1:0];
  assign o_data_mem      = acc_q;
  assign o_acc           = acc_q;
  assign o_halt          = halt_q;
  assign o_cycle_count   = cnt_q;

endmodule

// File: doc/bip_datapath.md
Name: bip_datapath

Overview:
- Execution datapath of the BIP I processor, directly downstream of the control unit.
- Consumes the control unit's selA/selB/wrAcc/opCode and the instruction operand field, and holds the accumulator (ACC).
- Drives the data-memory address and write data.
- Adds a sticky halt latch and a cycle counter for the debug/UART reporting path.

Parameters:
- OPCODE_LENGTH, 5, opcode width
- OPERAND_LENGTH, 11, instruction operand width (signed immediate or data address)
- DATA_LENGTH, 16, accumulator and data-memory word width
- DATA_ADDR_BITS, 11, data-memory address width (≤ OPERAND_LENGTH)
- CNT_BITS, 32, cycle counter width

Ports:
- i_clock  in  1  system clock, all state on rising edge
- i_soft_reset  in  1  synchronous, active-low reset
- i_opcode  in  OPCODE_LENGTH  decoded opcode from control unit
- i_operand  in  OPERAND_LENGTH  operand field of current instruction
- i_selA  in  2  ACC source select
- i_selB  in  1  ALU B-operand select
- i_wrAcc  in  1  ACC write enable
- i_data_mem  in  DATA_LENGTH  read data from data memory
- o_addr_data_mem  out  DATA_ADDR_BITS  data-memory address
- o_data_mem  out  DATA_LENGTH  data-memory write data (= ACC)
- o_acc  out  DATA_LENGTH  accumulator value
- o_halt  out  1  sticky halt flag
- o_cycle_count  out  CNT_BITS  cycles executed since reset

Behaviour:
- Reset: i_soft_reset=0 sampled at a rising edge sets ACC=0, o_halt=0, o_cycle_count=0.
  - Reset overrides every other input on that edge, including i_wrAcc and HLT.
  - Reset during halt clears halt.
- Sign extension: EXT = i_operand sign-extended to DATA_LENGTH.
- B operand: i_selB=0 → i_data_mem; i_selB=1 → EXT.
- ALU, combinational, modulo 2^DATA_LENGTH, no carry or overflow flags:
  - opcodes 00100 (ADD) and 00101 (ADDI) → ACC + B
  - opcodes 00110 (SUB) and 00111 (SUBI) → ACC − B
  - any other opcode → B (pass-through)
- ACC next-value mux:
  - i_selA=0 → i_data_mem
  - i_selA=1 → EXT
  - i_selA=2 → ALU result
  - i_selA=3 → current ACC (hold)
- ACC update: loads at the rising edge when i_soft_reset=1, i_wrAcc=1 and o_halt=0.
  - Otherwise ACC holds.
  - One-cycle latency: the new value is visible on o_acc immediately after that edge.
- Memory interface, combinational:
  - o_addr_data_mem = i_operand[DATA_ADDR_BITS-1:0]
  - o_data_mem = ACC
  - Write-enable is owned by the control unit, so STO presents the pre-edge ACC.
- Halt:
  - At a rising edge with i_soft_reset=1 and i_opcode=00000 (HLT), o_halt becomes 1.
  - It stays 1 until reset.
  - While o_halt=1, ACC is frozen regardless of i_wrAcc/i_selA.
  - If HLT and i_wrAcc=1 arrive together, ACC still updates on that edge; the freeze applies from the next edge.
- Cycle counter:
  - At every rising edge with i_soft_reset=1 and o_halt=0 (pre-edge value), the counter increments by 1.
  - The edge that sets halt therefore counts.
  - It saturates at all-ones (no wrap).
  - Frozen while halted.
- Unknown/X-free requirement: every register has a defined value after the first reset edge. The first edge after power-up must have i_soft_reset=0.

Test Plan:
1. Reset, then LDI 5 (op 00011, operand 0x005, selA=1, wrAcc=1), then ADDI −3 (op 00101, operand 0x7FD, selA=2, selB=1, wrAcc=1) → o_acc=0x0005 then 0x0002; o_cycle_count=2.
2. LD with i_data_mem=0x1234 (selA=0, wrAcc=1), then SUB with i_data_mem=0x1235 (op 00110, selA=2, selB=0) → o_acc=0x1234 then 0xFFFF (wrap).
3. ACC=0x7FFF, ADDI 1 → 0x8000; ACC=0xFFFF, ADDI 1 → 0x0000. Also ADDI with operand 0x400 → adds 0xFC00.
4. STO with operand 0x00A, ACC=0x0042, wrAcc=0 → o_addr_data_mem=0x00A, o_data_mem=0x0042, ACC unchanged after edge. Then selA=3, wrAcc=1 → ACC unchanged.
5. LDI 1, ADDI 1, ADDI 1, HLT, then LDI 9 with wrAcc=1 for 5 cycles → o_halt=1 after the 4th edge; o_acc=0x0003; o_cycle_count=4 and stays 4.
6. i_soft_reset=0 for one edge while halted with wrAcc=1/LDI 7 → o_acc=0, o_halt=0, count=0. Separately, with CNT_BITS=4, run 20 non-halt cycles → o_cycle_count=15 (saturated).
